// File: rtl/rv32i_types_pkg.sv
// Shared RV32/RVV scalar-side types used across the core.
package rv32i_types_pkg;

    // Vector element width code: 0=8, 1=16, 2=32, 3=64 bits.
    typedef logic [1:0] sew_t;

endpackage

// File: rtl/vector_uop_sequencer_pkg.sv
// Types and helpers for the vector micro-op sequencer.
package vector_uop_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } vseq_state_t;

    // log2 of elements per register for a width code; code 4 (widen from 64) clamps to 3.
    function automatic int epr_log2(input int vlen, input logic [2:0] wcode);
        logic [2:0] w;
        w = (wcode > 3'd3) ? 3'd3 : wcode;
        return $clog2(vlen) - 3 - int'(w);
    endfunction

endpackage

// File: rtl/vseq_offset_calc.sv
// Maps an element index and width code to a 3-bit register offset within the group.
// Combinational, no backpressure.
module vseq_offset_calc
    import vector_uop_sequencer_pkg::*;
#(
    parameter int VLEN     = 128,
    parameter int VL_WIDTH = 8
) (
    input  logic [VL_WIDTH-1:0] idx,
    input  logic [2:0]          wcode,
    output logic [2:0]          off
);

    assign off = 3'(idx >> epr_log2(VLEN, wcode));

endmodule

// File: rtl/vector_uop_sequencer.sv
// Steps one vector instruction into LANES-wide micro-ops; first uop one cycle after accept.
// stall holds all outputs; flush returns to idle without a done pulse. Option: VSEQ_MASK_EN.
module vector_uop_sequencer
    import vector_uop_sequencer_pkg::*;
    import rv32i_types_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int VLEN     = 128,
    parameter int VL_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    output logic                ready,
    input  logic [VL_WIDTH-1:0] vl,
    input  logic [VL_WIDTH-1:0] vstart,
    input  sew_t                sew,
    input  logic                vd_widen,
    input  logic                vd_narrow,
`ifdef VSEQ_MASK_EN
    input  logic                vm,
    input  logic [LANES-1:0]    v0_bits,
`endif
    input  logic                stall,
    input  logic                flush,
    output logic                uop_valid,
    output logic [VL_WIDTH-1:0] elem_idx,
    output logic [2:0]          vs1_off,
    output logic [2:0]          vs2_off,
    output logic [2:0]          vd_off,
    output logic [LANES-1:0]    lane_mask,
    output logic                last,
    output logic                done,
    output logic                busy
);

    vseq_state_t         state;
    logic [VL_WIDTH-1:0] idx;
    logic [VL_WIDTH-1:0] lat_vl;
    sew_t                lat_sew;
    logic                lat_widen;
    logic                lat_narrow;
`ifdef VSEQ_MASK_EN
    logic                lat_vm;
`endif

    logic                run;
    logic [VL_WIDTH:0]   idx_sum;
    logic                last_grp;
    logic [LANES-1:0]    tail_mask;
    logic [2:0]          w_vs1, w_vs2, w_vd;
    logic [2:0]          off_vs1, off_vs2, off_vd;

    assign run      = (state == ST_RUN);
    // One extra bit so idx + LANES cannot wrap at the largest vl.
    assign idx_sum  = {1'b0, idx} + (VL_WIDTH+1)'(LANES);
    assign last_grp = (idx_sum >= {1'b0, lat_vl});

    always_comb begin
        tail_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            tail_mask[i] = (({1'b0, idx} + (VL_WIDTH+1)'(i)) < {1'b0, lat_vl});
        end
    end

    // Both flags high is illegal and behaves as plain single-width.
    assign w_vs1 = {1'b0, lat_sew};
    assign w_vs2 = {1'b0, lat_sew} + {2'b00, lat_narrow & ~lat_widen};
    assign w_vd  = {1'b0, lat_sew} + {2'b00, lat_widen & ~lat_narrow};

    vseq_offset_calc #(.VLEN(VLEN), .VL_WIDTH(VL_WIDTH)) u_off_vs1 (.idx(idx), .wcode(w_vs1), .off(off_vs1));
    vseq_offset_calc #(.VLEN(VLEN), .VL_WIDTH(VL_WIDTH)) u_off_vs2 (.idx(idx), .wcode(w_vs2), .off(off_vs2));
    vseq_offset_calc #(.VLEN(VLEN), .VL_WIDTH(VL_WIDTH)) u_off_vd  (.idx(idx), .wcode(w_vd),  .off(off_vd));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            idx        <= '0;
            lat_vl     <= '0;
            lat_sew    <= '0;
            lat_widen  <= 1'b0;
            lat_narrow <= 1'b0;
`ifdef VSEQ_MASK_EN
            lat_vm     <= 1'b0;
`endif
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx        <= vstart;
                        lat_vl     <= vl;
                        lat_sew    <= sew;
                        lat_widen  <= vd_widen;
                        lat_narrow <= vd_narrow;
`ifdef VSEQ_MASK_EN
                        lat_vm     <= vm;
`endif
                        state      <= (vstart >= vl) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        idx <= idx_sum[VL_WIDTH-1:0];
                        if (last_grp) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Datapath outputs are gated to zero outside RUN so idle values stay clean.
    assign ready     = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign uop_valid = run;
    assign elem_idx  = run ? idx : '0;
    assign vs1_off   = run ? off_vs1 : 3'd0;
    assign vs2_off   = run ? off_vs2 : 3'd0;
    assign vd_off    = run ? off_vd : 3'd0;
    assign last      = run & last_grp;
`ifdef VSEQ_MASK_EN
    assign lane_mask = run ? (tail_mask & (lat_vm ? {LANES{1'b1}} : v0_bits)) : '0;
`else
    assign lane_mask = run ? tail_mask : '0;
`endif

endmodule

// File: tb/tb_vector_uop_sequencer.sv
// Directed, table-driven bench for vector_uop_sequencer (LANES=2, VLEN=128, VL_WIDTH=8).
module tb_vector_uop_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start, ready;
    logic [7:0] vl, vstart;
    logic [1:0] sew;
    logic       vd_widen, vd_narrow;
`ifdef VSEQ_MASK_EN
    logic       vm;
    logic [1:0] v0_bits;
`endif
    logic       stall, flush;
    logic       uop_valid;
    logic [7:0] elem_idx;
    logic [2:0] vs1_off, vs2_off, vd_off;
    logic [1:0] lane_mask;
    logic       last, done, busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    vector_uop_sequencer #(.LANES(2), .VLEN(128), .VL_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .ready(ready),
        .vl(vl), .vstart(vstart), .sew(sew),
        .vd_widen(vd_widen), .vd_narrow(vd_narrow),
`ifdef VSEQ_MASK_EN
        .vm(vm), .v0_bits(v0_bits),
`endif
        .stall(stall), .flush(flush),
        .uop_valid(uop_valid), .elem_idx(elem_idx),
        .vs1_off(vs1_off), .vs2_off(vs2_off), .vd_off(vd_off),
        .lane_mask(lane_mask), .last(last), .done(done), .busy(busy)
    );

    typedef struct {
        int vl;
        int vstart;
        int sew;
        int widen;
        int narrow;
        int exp_uops;
        int exp_last_idx;
        int exp_last_mask;
        int exp_last_vs1;
        int exp_last_vs2;
        int exp_last_vd;
    } vec_t;

    vec_t rows [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic issue(input int v_vl, input int v_vs, input int v_sew, input int w, input int n);
        @(negedge CLK);
        vl = 8'(v_vl); vstart = 8'(v_vs); sew = 2'(v_sew);
        vd_widen = w[0]; vd_narrow = n[0]; start = 1'b1;
        check("accept_ready", {31'd0, ready}, 1);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  nuops, lastcnt, li, lm, l1, l2, ld;
        bit  seen_done;
        nuops = 0; lastcnt = 0; seen_done = 0;
        li = 0; lm = 0; l1 = 0; l2 = 0; ld = 0;
        issue(v.vl, v.vstart, v.sew, v.widen, v.narrow);
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            if (uop_valid) begin
                check("tbl_elem_idx", {24'd0, elem_idx}, v.vstart + 2 * nuops);
                nuops++;
                if (last) lastcnt++;
                li = int'(elem_idx); lm = int'(lane_mask);
                l1 = int'(vs1_off); l2 = int'(vs2_off); ld = int'(vd_off);
            end
            if (done) begin
                seen_done = 1;
                check("tbl_done_cycle", cyc, v.exp_uops);
            end
        end
        check("tbl_done_seen", {31'd0, seen_done}, 1);
        check("tbl_uop_count", nuops, v.exp_uops);
        check("tbl_last_count", lastcnt, (v.exp_uops > 0) ? 1 : 0);
        if (v.exp_uops > 0) begin
            check("tbl_last_idx", li, v.exp_last_idx);
            check("tbl_last_mask", lm, v.exp_last_mask);
            check("tbl_last_vs1", l1, v.exp_last_vs1);
            check("tbl_last_vs2", l2, v.exp_last_vs2);
            check("tbl_last_vd", ld, v.exp_last_vd);
        end
        @(negedge CLK);
        check("tbl_ready_after", {31'd0, ready}, 1);
        check("tbl_done_once", {31'd0, done}, 0);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_ready"}, {31'd0, ready}, 1);
        check({nm, "_uop_valid"}, {31'd0, uop_valid}, 0);
        check({nm, "_busy"}, {31'd0, busy}, 0);
        check({nm, "_done"}, {31'd0, done}, 0);
        check({nm, "_last"}, {31'd0, last}, 0);
        check({nm, "_elem_idx"}, {24'd0, elem_idx}, 0);
        check({nm, "_lane_mask"}, {30'd0, lane_mask}, 0);
        check({nm, "_offs"}, {23'd0, vs1_off, vs2_off, vd_off}, 0);
    endtask

    initial begin
        //          vl  vst sew  w  n  uops lidx lmsk vs1 vs2 vd
        rows[0] = '{  7,   0, 2, 0, 0,  4,   6,  1,  1,  1,  1};
        rows[1] = '{  0,   0, 2, 0, 0,  0,   0,  0,  0,  0,  0};
        rows[2] = '{  5,   5, 2, 0, 0,  0,   0,  0,  0,  0,  0};
        rows[3] = '{ 20,   0, 0, 1, 0, 10,  18,  3,  1,  1,  2};
        rows[4] = '{  9,   3, 1, 0, 1,  3,   7,  3,  0,  1,  0};
        rows[5] = '{ 16,  14, 3, 1, 1,  1,  14,  3,  7,  7,  7};
        rows[6] = '{ 32,  30, 3, 1, 0,  1,  30,  3,  7,  7,  7};
        rows[7] = '{255, 254, 0, 0, 0,  1, 254,  1,  7,  7,  7};

        RST = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
        vl = '0; vstart = '0; sew = '0; vd_widen = 1'b0; vd_narrow = 1'b0;
`ifdef VSEQ_MASK_EN
        vm = 1'b1; v0_bits = 2'b11;
`endif
        #12;
        check_idle_outputs("reset");
        @(negedge CLK);
        RST = 1'b0;

        for (int r = 0; r < 8; r++) run_vec(rows[r]);

        // vl=7, sew=32: per-uop mask, vd offset and last.
        begin
            int exp_mask [4] = '{3, 3, 3, 1};
            int exp_vd   [4] = '{0, 0, 1, 1};
            int exp_last [4] = '{0, 0, 0, 1};
            issue(7, 0, 2, 0, 0);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge CLK);
                check("seq7_valid", {31'd0, uop_valid}, 1);
                check("seq7_idx", {24'd0, elem_idx}, 2 * k);
                check("seq7_mask", {30'd0, lane_mask}, exp_mask[k]);
                check("seq7_vd", {29'd0, vd_off}, exp_vd[k]);
                check("seq7_last", {31'd0, last}, exp_last[k]);
                check("seq7_ready", {31'd0, ready}, 0);
            end
            @(negedge CLK);
            check("seq7_done", {31'd0, done}, 1);
            check("seq7_ready_in_done", {31'd0, ready}, 0);
            @(negedge CLK);
            check("seq7_ready_after", {31'd0, ready}, 1);
            check("seq7_done_after", {31'd0, done}, 0);
        end

        // Stall for three edges while idx=2 is presented.
        begin
            int  valid_cyc, idx2_cyc, stall_cnt;
            bit  seen_done;
            valid_cyc = 0; idx2_cyc = 0; stall_cnt = 0; seen_done = 0;
            issue(8, 0, 2, 0, 0);
            for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
                if (cyc > 0) @(negedge CLK);
                if (uop_valid) valid_cyc++;
                if (done) seen_done = 1;
                if (uop_valid && elem_idx == 8'd2) begin
                    idx2_cyc++;
                    check("stall_mask", {30'd0, lane_mask}, 3);
                    check("stall_offs", {23'd0, vs1_off, vs2_off, vd_off}, 0);
                    check("stall_last", {31'd0, last}, 0);
                end
                if (uop_valid && elem_idx == 8'd2 && stall_cnt < 3) begin
                    stall = 1'b1;
                    stall_cnt++;
                end else begin
                    stall = 1'b0;
                end
            end
            stall = 1'b0;
            check("stall_done_seen", {31'd0, seen_done}, 1);
            check("stall_idx2_cycles", idx2_cyc, 4);
            check("stall_valid_cycles", valid_cyc, 7);
            @(negedge CLK);
        end

        // Flush together with stall at idx 4.
        begin
            bit hit, any_done;
            hit = 0; any_done = 0;
            issue(16, 0, 2, 0, 0);
            for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
                if (cyc > 0) @(negedge CLK);
                if (uop_valid && elem_idx == 8'd4) hit = 1;
            end
            check("flush_reached_idx4", {31'd0, hit}, 1);
            flush = 1'b1; stall = 1'b1;
            @(negedge CLK);
            flush = 1'b0; stall = 1'b0;
            check_idle_outputs("flush");
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK);
                if (done || uop_valid) any_done = 1;
            end
            check("flush_quiet_after", {31'd0, any_done}, 0);
        end

        // Asynchronous reset in the middle of a run.
        issue(20, 0, 0, 1, 0);
        @(negedge CLK);
        check("rst_pre_valid", {31'd0, uop_valid}, 1);
        RST = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge CLK);
        RST = 1'b0;

`ifdef VSEQ_MASK_EN
        vm = 1'b0; v0_bits = 2'b10;
        issue(3, 0, 2, 0, 0);
        check("mask_full", {30'd0, lane_mask}, 2);
        @(negedge CLK);
        check("mask_tail", {30'd0, lane_mask}, 0);
        check("mask_tail_last", {31'd0, last}, 1);
        vm = 1'b1; v0_bits = 2'b11;
        @(negedge CLK);
        @(negedge CLK);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=1 required=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vector_uop_sequencer.md
Name: vector_uop_sequencer

Overview:
- Sequences one decoded vector instruction into per-cycle element-group micro-ops for the vector execute lanes.
- Accepts vl/vstart/sew plus widen/narrow flags from the vector decode/control stage and steps an element counter LANES at a time.
- Drives the register-group offsets (vs1/vs2/vd) and a per-lane active mask.
- Honours backend stall and pipeline flush; sits between vector decode and the vector register-file read stage.

Parameters:
- LANES, 2, elements processed per micro-op; power of two, 1..8.
- VLEN, 128, vector register length in bits.
- VL_WIDTH, 8, width of vl/vstart/element index; must satisfy 2^VL_WIDTH > 8*VLEN/8.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  instruction valid from decode; accepted only when ready=1.
- ready  out  1  sequencer idle and able to accept start.
- vl  in  VL_WIDTH  vector length, sampled on accept.
- vstart  in  VL_WIDTH  first element index, sampled on accept.
- sew  in  2  element width code: 0=8, 1=16, 2=32, 3=64 bits; sampled on accept.
- vd_widen  in  1  vd uses 2*SEW; sampled.
- vd_narrow  in  1  vs2 uses 2*SEW; sampled. vd_widen and vd_narrow both high is illegal: treated as neither.
- stall  in  1  backend cannot take a micro-op; hold all outputs.
- flush  in  1  abort the current instruction.
- uop_valid  out  1  micro-op outputs are valid this cycle.
- elem_idx  out  VL_WIDTH  index of lane 0 element.
- vs1_off, vs2_off, vd_off  out  3 each  register offset within group.
- lane_mask  out  LANES  bit i = lane i active.
- last  out  1  final micro-op of the instruction.
- done  out  1  one-cycle pulse when the instruction completes.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - ready=1; all other outputs 0.
  - Internal counters 0; state IDLE.
- States: IDLE, RUN, DONE.
- IDLE
  - ready=1.
  - On start: latch the inputs and set idx=vstart.
  - If vstart >= vl (includes vl=0): go to DONE; no micro-ops are issued.
  - Otherwise go to RUN.
- RUN
  - uop_valid=1 and ready=0.
  - Outputs are combinational from the latched idx.
  - When stall=0: idx advances by LANES. If last=1, go to DONE.
  - When stall=1: idx and all outputs are held unchanged.
  - First micro-op appears the cycle after accept.
- DONE
  - done=1 for exactly one cycle, then IDLE; ready returns 1 in that next cycle.
  - Back-to-back start is not accepted in DONE.
- Elements per register: EPR(w) = VLEN/(8<<w), computed as a shift.
  - vs1 and vs2 use sew; vs2 uses sew+1 when vd_narrow.
  - vd uses sew+1 when vd_widen.
  - A width code of 4 (widen from 64) saturates at 3.
- Register offsets:
  - Each offset = idx >> log2(EPR) of that operand, truncated to 3 bits (max LMUL=8).
  - The offset is taken from lane 0 only; LANES never spans a register boundary because EPR >= LANES is required.
- last = (idx + LANES >= vl).
- lane_mask[i] = (idx + i < vl); tail lanes are masked.
- Full-width arithmetic: idx + LANES is computed at VL_WIDTH+1 bits, so there is no wrap at the maximum vl.
- flush has priority over stall and start. In any state it forces IDLE on the next edge: uop_valid=0, and done is not pulsed.
- RST asserted mid-RUN: outputs go to reset values immediately (asynchronous).

Optional Feature:
- Macro: VSEQ_MASK_EN.
- With the macro defined, two extra ports exist:
  - vm (in, 1; sampled on accept).
  - v0_bits (in, LANES; mask bits for the current group, supplied by the RF read stage).
- With the macro, lane_mask becomes (tail mask) AND (vm ? all-ones : v0_bits).
- Without the macro: no such ports; lane_mask is the tail mask only.

Decomposition:
- Shared package: vseq_state_t enum (IDLE, RUN, DONE) and the width-code-to-log2(EPR) constant function.
  - Reuse sew_t from rv32i_types_pkg for the sew port type.
- One sub-module: vseq_offset_calc, a combinational block mapping (idx, width code) to a 3-bit offset. It is instantiated three times.

Test Plan:
- sew=2, vl=7, vstart=0, no widen: micro-ops at elem_idx 0,2,4,6.
  - lane_mask 11,11,11,01.
  - vd_off 0,0,1,1.
  - last only on idx 6.
  - done pulses the following cycle; ready=1 the cycle after.
- vl=0 start: no uop_valid; done pulses the cycle after accept. Repeat with vstart=5, vl=5: same result.
- sew=2, vl=8, stall=1 for 3 cycles on idx 2: elem_idx, offsets, mask and uop_valid are held for 3 cycles; total run is 4 micro-ops plus 3 stall cycles.
- sew=0, vd_widen=1, vl=20: at idx 16, vs2_off=1 and vd_off=2; final micro-op idx 18, mask 11, last=1.
- flush asserted together with stall at idx 4 (vl=16): next cycle IDLE, ready=1, uop_valid=0, no done pulse.
- RST pulsed asynchronously mid-RUN: ready=1 and all other outputs 0 immediately.
- With VSEQ_MASK_EN, vm=0, v0_bits=10: lane_mask=10 on full groups and 00 on a tail where only lane 0 is active.
